// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared constants for the ID-stage hazard scoreboard:
//   - RV32 opcodes that the stall logic classifies (branch, jalr, store, load)
//   - producer latency classes, counted in cycles after EX entry until the
//     result can be forwarded to EX
//   - the scoreboard count type at the default latency-field width
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;

    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;
    localparam int LAT_MUL  = 3;

    // Default producer-latency field width. A count has two extra bits so that
    // the largest latency plus the branch-forwarding slack still fits.
    localparam int SB_LAT_W = 3;
    localparam int SB_CNT_W = SB_LAT_W + 2;

    typedef logic [SB_CNT_W-1:0] sb_cnt_t;

endpackage

// File: rtl/hazard_sb_entry.sv
// -----------------------------------------------------------------------------
// hazard_sb_entry
// One scoreboard counter: the number of cycles until its register's value can
// be forwarded into ID.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (clears the count)
//   alloc_i   - an instruction writing this register issues this cycle
//   freeze_i  - EX is busy; producers do not advance, so the count holds
//   lat_i     - count to load on issue (producer latency + branch slack)
//   cnt_o     - current count
// -----------------------------------------------------------------------------
module hazard_sb_entry
    import hazard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_i,
    input  logic             freeze_i,
    input  logic [CNT_W-1:0] lat_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_dec;

    assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

    // A new producer never shortens the wait of an older, slower one (WAW):
    // the loaded value is the larger of the decremented count and the new one.
    always_comb begin
        cnt_d = cnt_q;
        if (!freeze_i) begin
            cnt_d = cnt_dec;
            if (alloc_i && (lat_i > cnt_dec)) begin
                cnt_d = lat_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// ID-stage stall unit for the 5-stage RV32 pipeline built on a per-register
// countdown scoreboard. Looks up the counts of the ID sources, decides whether
// the ID instruction must wait, and allocates a count for its destination when
// it issues.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   id_valid                  - IF/ID holds a live instruction
//   id_opcode                 - opcode of the ID instruction
//   id_rs1/id_rs2             - source registers, with id_rs1_used/id_rs2_used
//   id_rd, id_reg_write       - destination register and its write enable
//   id_lat                    - producer latency class of the ID instruction
//   ex_busy                   - multi-cycle EX unit holds the pipe
//   pc_write, if_id_write     - 1 lets the PC / IF/ID register advance
//   control_sel               - 0 zeroes the ID/EX controls (bubble)
//   stall_cycles              - stall performance counter
// Build option:
//   HAZ_PERF_CNT_EN - when defined, stall_cycles counts stalled cycles
//                     (wrapping); otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int RA_W     = $clog2(NUM_REGS),
    parameter int LAT_W    = SB_LAT_W,
    parameter int BR_EXTRA = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [6:0]      id_opcode,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_reg_write,
    input  logic [LAT_W-1:0] id_lat,
    input  logic            ex_busy,
    output logic            pc_write,
    output logic            if_id_write,
    output logic            control_sel,
    output logic [31:0]     stall_cycles
);

    localparam int CNT_W = LAT_W + 2;

    // Normal consumers read forwarded values in EX, one slack window after an
    // early (ID) consumer; store data is needed only at MEM, one more later.
    localparam logic [CNT_W-1:0] THR_NORM  = CNT_W'(BR_EXTRA);
    localparam logic [CNT_W-1:0] THR_STORE = CNT_W'(BR_EXTRA + 1);

    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic [CNT_W-1:0] rs1_cnt;
    logic [CNT_W-1:0] rs2_cnt;
    logic [CNT_W-1:0] lat_ext;
    logic             is_early;
    logic             is_store;
    logic             haz_rs1;
    logic             haz_rs2;
    logic             stall;
    logic             issue;
    logic             run;

    // x0 is never tracked; its count reads as permanently ready.
    assign cnt[0] = '0;

    assign lat_ext = CNT_W'(id_lat) + CNT_W'(BR_EXTRA);

    genvar r;
    generate
        for (r = 1; r < NUM_REGS; r++) begin : g_sb
            hazard_sb_entry #(
                .CNT_W (CNT_W)
            ) u_entry (
                .clk      (clk),
                .rst      (rst),
                .alloc_i  (issue && id_reg_write && (id_rd == RA_W'(r))),
                .freeze_i (ex_busy),
                .lat_i    (lat_ext),
                .cnt_o    (cnt[r])
            );
        end
    endgenerate

    assign is_early = (id_opcode == OPC_BRANCH) || (id_opcode == OPC_JALR);
    assign is_store = (id_opcode == OPC_STORE);

    assign rs1_cnt = cnt[id_rs1];
    assign rs2_cnt = cnt[id_rs2];

    always_comb begin
        haz_rs1 = 1'b0;
        if (id_rs1_used && (id_rs1 != '0)) begin
            haz_rs1 = is_early ? (rs1_cnt != '0) : (rs1_cnt > THR_NORM);
        end
    end

    always_comb begin
        haz_rs2 = 1'b0;
        if (id_rs2_used && (id_rs2 != '0)) begin
            if (is_early) begin
                haz_rs2 = (rs2_cnt != '0);
            end else if (is_store) begin
                haz_rs2 = (rs2_cnt > THR_STORE);
            end else begin
                haz_rs2 = (rs2_cnt > THR_NORM);
            end
        end
    end

    // ex_busy stalls a live instruction, so it also blocks allocation.
    assign stall = id_valid && (haz_rs1 || haz_rs2 || ex_busy);
    assign issue = id_valid && !stall;

    // Reset forces all enables low while it is held.
    assign run         = !rst && !stall;
    assign pc_write    = run;
    assign if_id_write = run;
    assign control_sel = run;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;

    assign stall_cycles_d = stall ? stall_cycles_q + 32'd1 : stall_cycles_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NREG = 32;
    localparam int BRX  = 1;
    localparam logic [6:0] OPC_OP = 7'b0110011;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic [2:0]  id_lat;
    logic        ex_busy;
    logic        pc_write;
    logic        if_id_write;
    logic        control_sel;
    logic [31:0] stall_cycles;

    int vectors;
    int miscompares;

    hazard_scoreboard #(
        .NUM_REGS (NREG),
        .LAT_W    (3),
        .BR_EXTRA (BRX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_opcode    (id_opcode),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_lat       (id_lat),
        .ex_busy      (ex_busy),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .control_sel  (control_sel),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: time is measured in "advance steps" (cycles where EX is not
    // busy). Each register holds the step at which it becomes forwardable
    // into ID; its remaining wait is that step minus the current step.
    // ------------------------------------------------------------------
    int adv;
    int ready_at [NREG];
    int perf_exp;

    function automatic int remaining(input logic [4:0] r);
        int d;
        if (r == 5'd0) return 0;
        d = ready_at[r] - adv;
        return (d > 0) ? d : 0;
    endfunction

    function automatic bit model_stall();
        bit early, store, h1, h2;
        early = (id_opcode == OPC_BRANCH) || (id_opcode == OPC_JALR);
        store = (id_opcode == OPC_STORE);
        h1 = id_rs1_used && (remaining(id_rs1) > (early ? 0 : BRX));
        h2 = id_rs2_used && (remaining(id_rs2) > (early ? 0 : (store ? BRX + 1 : BRX)));
        return id_valid && (h1 || h2 || ex_busy);
    endfunction

    always @(negedge clk) begin
        bit st;
        bit run;
        int tgt;
        st  = model_stall();
        run = !rst && !st;
        chk("pc_write", {31'd0, pc_write}, {31'd0, run});
        chk("if_id_write", {31'd0, if_id_write}, {31'd0, run});
        chk("control_sel", {31'd0, control_sel}, {31'd0, run});
`ifdef HAZ_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, perf_exp);
`else
        chk("stall_cycles", stall_cycles, 32'd0);
`endif
        // advance the model to the state after the coming posedge
        if (rst) begin
            adv = 0;
            foreach (ready_at[i]) ready_at[i] = 0;
            perf_exp = 0;
        end else begin
            if (st) perf_exp++;
            if (!ex_busy) begin
                if (id_valid && !st && id_reg_write && id_rd != 5'd0) begin
                    tgt = adv + 1 + int'(id_lat) + BRX;
                    if (tgt > ready_at[id_rd]) ready_at[id_rd] = tgt;
                end
                adv++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drv(input logic [6:0] op, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic rw, input int lat);
        id_valid     = 1'b1;
        id_opcode    = op;
        id_rs1       = rs1;
        id_rs1_used  = u1;
        id_rs2       = rs2;
        id_rs2_used  = u2;
        id_rd        = rd;
        id_reg_write = rw;
        id_lat       = 3'(lat);
    endtask

    task automatic idle();
        id_valid     = 1'b0;
        id_rs1_used  = 1'b0;
        id_rs2_used  = 1'b0;
        id_reg_write = 1'b0;
    endtask

    // Counts stalled cycles of the instruction in ID until it issues.
    task automatic wait_issue(input int exp, input string name);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            if (pc_write === 1'b1) begin
                done = 1;
            end else begin
                n++;
                if (n > 20) done = 1;
                else begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        @(posedge clk);
        #1;
        idle();
        chk(name, n, exp);
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, input int lat, input int exp, input string name);
        drv(op, rs1, u1, rs2, u2, rd, rw, lat);
        wait_issue(exp, name);
    endtask

    task automatic bubble();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        adv         = 0;
        perf_exp    = 0;
        foreach (ready_at[i]) ready_at[i] = 0;
        rst       = 1'b1;
        ex_busy   = 1'b0;
        id_opcode = OPC_OP;
        id_rs1    = '0;
        id_rs2    = '0;
        id_rd     = '0;
        id_lat    = '0;
        idle();

        // reset state
        @(negedge clk);
        chk("reset pc_write", {31'd0, pc_write}, 32'd0);
        chk("reset control_sel", {31'd0, control_sel}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset pc_write", {31'd0, pc_write}, 32'd1);
        @(posedge clk);
        #1;

        // load-use
        send(OPC_LOAD, 5'd1, 1, 5'd0, 0, 5'd5, 1, LAT_LOAD, 0, "lw x5");
        send(OPC_OP, 5'd5, 1, 5'd7, 1, 5'd6, 1, LAT_ALU, 1, "load-use add");

        // producers into a branch
        send(OPC_OP, 5'd1, 1, 5'd2, 1, 5'd3, 1, LAT_ALU, 0, "add x3");
        send(OPC_BRANCH, 5'd3, 1, 5'd0, 1, 5'd0, 0, 0, 1, "alu-branch");
        send(OPC_LOAD, 5'd1, 1, 5'd0, 0, 5'd3, 1, LAT_LOAD, 0, "lw x3");
        send(OPC_BRANCH, 5'd3, 1, 5'd0, 1, 5'd0, 0, 0, 2, "load-branch");
        send(OPC_OP, 5'd1, 1, 5'd2, 1, 5'd3, 1, LAT_ALU, 0, "add x3 b");
        bubble();
        send(OPC_BRANCH, 5'd3, 1, 5'd0, 1, 5'd0, 0, 0, 0, "alu-nop-branch");
        send(OPC_OP, 5'd1, 1, 5'd2, 1, 5'd14, 1, LAT_ALU, 0, "add x14");
        send(OPC_JALR, 5'd14, 1, 5'd0, 0, 5'd1, 1, LAT_ALU, 1, "alu-jalr");

        // store data versus store base
        send(OPC_LOAD, 5'd1, 1, 5'd0, 0, 5'd8, 1, LAT_LOAD, 0, "lw x8");
        send(OPC_STORE, 5'd2, 1, 5'd8, 1, 5'd0, 0, 0, 0, "store data");
        send(OPC_LOAD, 5'd1, 1, 5'd0, 0, 5'd2, 1, LAT_LOAD, 0, "lw x2");
        send(OPC_STORE, 5'd2, 1, 5'd8, 1, 5'd0, 0, 0, 1, "store base");
        send(OPC_OP, 5'd1, 1, 5'd2, 1, 5'd13, 1, LAT_MUL, 0, "mul x13");
        send(OPC_STORE, 5'd2, 1, 5'd13, 1, 5'd0, 0, 0, 2, "store data mul");

        // ex_busy freezes counts while a consumer waits
        send(OPC_OP, 5'd1, 1, 5'd2, 1, 5'd9, 1, LAT_MUL, 0, "mul x9");
        drv(OPC_OP, 5'd9, 1, 5'd1, 1, 5'd11, 1, LAT_ALU);
        ex_busy = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("busy stall", {31'd0, pc_write}, 32'd0);
            @(posedge clk);
            #1;
        end
        ex_busy = 1'b0;
        wait_issue(3, "after busy");

        // ex_busy with an empty ID slot: no stall, counts frozen
        send(OPC_OP, 5'd1, 1, 5'd2, 1, 5'd12, 1, LAT_MUL, 0, "mul x12");
        ex_busy = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("busy empty slot", {31'd0, pc_write}, 32'd1);
            @(posedge clk);
            #1;
        end
        ex_busy = 1'b0;
        send(OPC_OP, 5'd12, 1, 5'd0, 0, 5'd15, 1, LAT_ALU, 3, "after busy empty");

        // WAW keeps the slower producer's count; x0 never tracked
        send(OPC_OP, 5'd1, 1, 5'd2, 1, 5'd4, 1, LAT_MUL, 0, "mul x4");
        send(OPC_OP, 5'd0, 0, 5'd0, 0, 5'd4, 1, LAT_ALU, 0, "add x4");
        send(OPC_OP, 5'd4, 1, 5'd0, 0, 5'd10, 1, LAT_ALU, 2, "waw consumer");
        send(OPC_LOAD, 5'd1, 1, 5'd0, 0, 5'd0, 1, LAT_LOAD, 0, "lw x0");
        send(OPC_OP, 5'd0, 1, 5'd0, 1, 5'd1, 1, LAT_ALU, 0, "x0 consumer");

        // reset while a dependent instruction is stalled
        send(OPC_LOAD, 5'd1, 1, 5'd0, 0, 5'd5, 1, LAT_LOAD, 0, "lw x5 b");
        drv(OPC_OP, 5'd5, 1, 5'd7, 1, 5'd6, 1, LAT_ALU);
        rst = 1'b1;
        @(negedge clk);
        chk("rst mid-stall pc_write", {31'd0, pc_write}, 32'd0);
        chk("rst mid-stall if_id_write", {31'd0, if_id_write}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("after rst pc_write", {31'd0, pc_write}, 32'd1);
        chk("after rst control_sel", {31'd0, control_sel}, 32'd1);
        chk("after rst stall_cycles", stall_cycles, 32'd0);
        @(posedge clk);
        #1;
        idle();
        repeat (3) bubble();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the ID-stage stall unit of the 5-stage RV32 pipeline.
- Replaces pairwise rd/rs comparisons with a per-register countdown scoreboard.
- Handles arbitrary producer latencies (load, multi-cycle mul), ID-resolved branches, store-data late forwarding and EX-busy freeze.
- Drives the PC enable, the IF/ID enable and the bubble-insertion select.

Parameters:
- NUM_REGS, 32, architectural registers tracked; x0 is never tracked.
- RA_W, $clog2(NUM_REGS), register-address width.
- LAT_W, 3, producer-latency field width; the maximum latency is 2**LAT_W-1.
- BR_EXTRA, 1, extra cycles before a result can be forwarded into ID for branch or jalr compares.

Ports:
- clk, input, 1, core clock.
- rst, input, 1, asynchronous active-high reset.
- id_valid, input, 1, IF/ID holds a live instruction.
- id_opcode, input, 7, opcode of the ID instruction.
- id_rs1, input, RA_W, source register 1.
- id_rs2, input, RA_W, source register 2.
- id_rs1_used, input, 1, rs1 is actually read.
- id_rs2_used, input, 1, rs2 is actually read.
- id_rd, input, RA_W, destination register.
- id_reg_write, input, 1, the instruction writes rd.
- id_lat, input, LAT_W, cycles after EX entry until the result is forwardable to EX (ALU 0, load 1, mul 3).
- ex_busy, input, 1, multi-cycle EX unit holds the pipe.
- pc_write, output, 1, 1 means the PC advances.
- if_id_write, output, 1, 1 means IF/ID loads.
- control_sel, output, 1, 0 means the ID/EX controls are zeroed (bubble).
- stall_cycles, output, 32, performance counter; present only under the optional feature.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Scoreboard state: cnt[r], LAT_W+2 bits wide, for r = 1..NUM_REGS-1. cnt[r] is the number of cycles until r's value is forwardable into ID.
- Reset: all cnt cleared to 0.
  - While rst is high, pc_write, if_id_write and control_sel are all 0.
  - Once rst is released they take their computed values; with all counts 0 that is 1.
  - Reset asserted mid-stall clears the scoreboard immediately.
- Classification:
  - early = opcode 1100011 (branch) or 1100111 (jalr).
  - store = opcode 0100011.
- Hazard per used source s, with s != 0:
  - early consumer: cnt[s] > 0.
  - store rs2: cnt[s] > BR_EXTRA+1, because store data is forwarded at MEM.
  - all other cases: cnt[s] > BR_EXTRA.
- stall = id_valid & (hazard on rs1 | hazard on rs2 | ex_busy).
- Outputs are combinational on the current cnt and inputs, with zero-cycle latency.
  - When stall = 1: pc_write = if_id_write = control_sel = 0.
  - Otherwise all three are 1.
- Issue: the instruction issues when id_valid & ~stall. If it also has id_reg_write and id_rd != 0, the next cnt[id_rd] = max(cnt[id_rd]-1 saturated at 0, id_lat + BR_EXTRA). This max rule handles WAW against an older, slower producer.
- Decrement: every cycle with ex_busy = 0, each non-issued nonzero cnt decrements by 1 and saturates at 0.
- ex_busy = 1: all counters freeze and no issue occurs, because the producers do not advance.
- id_valid = 0 (flushed slot): no stall and no issue; counters still decrement.
- Simultaneous issue and decrement on the same register: the issue rule wins, and it already includes the decrement.
- Sources equal to x0 never stall. id_rd = 0 never allocates.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: stall_cycles is a 32-bit register, reset to 0, that increments (wrapping) on every cycle with stall = 1.
- Undefined: the port still exists and is tied to 0, with no flops.

Decomposition:
- Package hazard_pkg holds:
  - the opcode localparams OPC_BRANCH, OPC_JALR, OPC_STORE, OPC_LOAD;
  - the latency-class constants LAT_ALU=0, LAT_LOAD=1, LAT_MUL=3;
  - the typedef for a scoreboard count.
- Sub-module hazard_sb_entry: one register's counter with its load, max, decrement and freeze logic. It is instantiated NUM_REGS-1 times by a generate loop.
- The top level does the source lookup muxes, stall combine and perf counter.

Test Plan:
1. Load-use: issue lw x5 (id_lat=1), next cycle `add x6,x5,x7` → exactly 1 stall cycle (pc_write=0, control_sel=0), then it issues.
2. ALU→branch: `add x3` then `beq x3,x0` → 1 stall; `lw x3` then `beq x3` → 2 stalls; `add x3`, nop, `beq x3` → 0 stalls.
3. Store data: `lw x8` then `sw x8,0(x2)` → 0 stalls; `lw x2` then `sw x8,0(x2)` → 1 stall on the base-address register.
4. ex_busy: mul x9 (id_lat=3) issued, ex_busy held high for 4 cycles, then a consumer of x9 → stall for the 4 busy cycles plus 3 more; cnt[9] frozen while busy.
5. WAW and x0: `mul x4`(3) followed by `add x4`(0) → cnt[4] keeps the mul's remaining count. `lw x0` then `add x1,x0,x0` → no stall.
6. Reset mid-stall: assert rst while cnt[5]=2 with a dependent instruction in ID → outputs 0 during reset, then 1 on the first cycle after release; with HAZ_PERF_CNT_EN defined, stall_cycles=0.
